// File: rtl/mem_pkg.sv
// Shared constants and types for the memory1 pipeline stage.
package mem_pkg;

   localparam int unsigned INST_W = 64;
   localparam int unsigned OPC_W  = 8;
   localparam int unsigned IMM_W  = 16;

   // Field positions inside the instruction word
   localparam int unsigned OPC_HI = 63;
   localparam int unsigned OPC_LO = 56;
   localparam int unsigned IMM_HI = 15;
   localparam int unsigned IMM_LO = 0;

   localparam logic [OPC_W-1:0]  OP_LOAD  = 8'h01;
   localparam logic [OPC_W-1:0]  OP_STORE = 8'h02;
   localparam logic [OPC_W-1:0]  OP_IN    = 8'h03;
   localparam logic [OPC_W-1:0]  OP_OUT   = 8'h04;
   localparam logic [INST_W-1:0] NOP_INST = 64'h0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      IN_WAIT  = 2'd1,
      OUT_WAIT = 2'd2,
      DONE     = 2'd3
   } io_state_e;

   // Extract the opcode field from an instruction word
   function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W-1:0] w);
      return w[OPC_HI:OPC_LO];
   endfunction

endpackage

// File: rtl/memory1_io_fsm.sv
// Blocking IN/OUT handshake controller: owns the I/O state, captured IN data
// and the memory1 stall indication.
module memory1_io_fsm
   import mem_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              is_in,
   input  logic              is_out,
   input  logic              go,
   input  logic [DATA_W-1:0] src2,
   input  logic              io_in_valid,
   input  logic [DATA_W-1:0] io_in_data,
   input  logic              io_out_ready,
   output logic              memory1_stall,
   output logic              io_in_ready,
   output logic              io_out_valid,
   output logic [DATA_W-1:0] io_out_data,
   output logic [DATA_W-1:0] io_data_to_the_next,
   output logic [31:0]       stall_cycles
);

   io_state_e state;
   io_state_e state_nxt;
   logic      stall;

   // State register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state and stall decode; an I/O op in IDLE stalls so upstream holds it
   always_comb begin
      state_nxt = state;
      stall     = 1'b0;
      case (state)
         IDLE: begin
            if (is_in) begin
               stall = 1'b1;
               if (go) state_nxt = IN_WAIT;
            end else if (is_out) begin
               stall     = 1'b1;
               state_nxt = OUT_WAIT;
            end
         end
         IN_WAIT: begin
            stall = 1'b1;
            if (io_in_valid) state_nxt = DONE;
         end
         OUT_WAIT: begin
            stall = 1'b1;
            if (io_out_ready) state_nxt = DONE;
         end
         DONE: begin
            if (go) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign memory1_stall = stall;

   // Registered handshake signals and data captured at state transitions
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         io_in_ready         <= 1'b0;
         io_out_valid        <= 1'b0;
         io_out_data         <= '0;
         io_data_to_the_next <= '0;
      end else begin
         io_in_ready  <= (state_nxt == IN_WAIT);
         io_out_valid <= (state_nxt == OUT_WAIT);
         if (state == IDLE && state_nxt == OUT_WAIT) io_out_data <= src2;
         if (state == IN_WAIT && io_in_valid) io_data_to_the_next <= io_in_data;
      end
   end

   // Saturating count of stalled cycles
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                             stall_cycles <= '0;
      else if (stall && stall_cycles != '1)  stall_cycles <= stall_cycles + 32'd1;
   end

endmodule

// File: rtl/memory1.sv
// First memory stage: effective address and BRAM port-B issue, I/O
// handshakes via memory1_io_fsm, and the pipeline register toward memory2.
module memory1
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W = 17,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              interlock,
   input  logic              memory2_stall,
   input  logic [63:0]       inst,
   input  logic [DATA_W-1:0] src1,
   input  logic [DATA_W-1:0] src2,
   output logic [63:0]       inst_to_the_next,
   output logic [DATA_W-1:0] io_data_to_the_next,
   output logic              memory1_stall,
   output logic [ADDR_W-1:0] addrb,
   output logic [DATA_W-1:0] dinb,
   output logic [3:0]        web,
   output logic              enb,
   output logic              io_in_ready,
   input  logic              io_in_valid,
   input  logic [DATA_W-1:0] io_in_data,
   output logic              io_out_valid,
   input  logic              io_out_ready,
   output logic [DATA_W-1:0] io_out_data,
   output logic [31:0]       stall_cycles
);

   logic [OPC_W-1:0]  opc;
   logic [IMM_W-1:0]  imm;
   logic [DATA_W-1:0] ea;
   logic              is_load;
   logic              is_store;
   logic              is_in;
   logic              is_out;
   logic              go;
   logic              advance;
   logic              unused_bits;

   // Decode and effective address generation
   always_comb begin
      opc      = opcode_of(inst);
      imm      = inst[IMM_HI:IMM_LO];
      is_load  = (opc == OP_LOAD);
      is_store = (opc == OP_STORE);
      is_in    = (opc == OP_IN);
      is_out   = (opc == OP_OUT);
      ea       = src1 + DATA_W'($signed(imm));
   end

   assign go      = ~memory2_stall | ~interlock;
   assign advance = ~memory1_stall & go;

   // BRAM port-B drive; enable low keeps doutb stable under downstream stall
   assign addrb = ea[ADDR_W-1:0];
   assign dinb  = src2;
   assign enb   = advance & (is_load | is_store);
   assign web   = (advance & is_store) ? 4'hF : 4'h0;

   assign unused_bits = ^{inst[OPC_LO-1:IMM_HI+1], ea[DATA_W-1:ADDR_W]};

   memory1_io_fsm #(
      .DATA_W (DATA_W)
   ) u_io_fsm (
      .clk                 (clk),
      .rstn                (rstn),
      .is_in               (is_in),
      .is_out              (is_out),
      .go                  (go),
      .src2                (src2),
      .io_in_valid         (io_in_valid),
      .io_in_data          (io_in_data),
      .io_out_ready        (io_out_ready),
      .memory1_stall       (memory1_stall),
      .io_in_ready         (io_in_ready),
      .io_out_valid        (io_out_valid),
      .io_out_data         (io_out_data),
      .io_data_to_the_next (io_data_to_the_next),
      .stall_cycles        (stall_cycles)
   );

   // Pipeline register: forward on advance, bubble while memory1 holds and memory2 drains
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                inst_to_the_next <= NOP_INST;
      else if (advance)                         inst_to_the_next <= inst;
      else if (memory1_stall && !memory2_stall) inst_to_the_next <= NOP_INST;
   end

endmodule

// File: tb/tb_memory1.sv
// Directed bench for memory1: BRAM issue, stall hold, IN/OUT handshakes, reset.
module tb_memory1;
   import mem_pkg::*;

   localparam int unsigned ADDR_W = 17;
   localparam int unsigned DATA_W = 32;

   logic              clk = 1'b0;
   logic              rstn;
   logic              interlock;
   logic              memory2_stall;
   logic [63:0]       inst;
   logic [DATA_W-1:0] src1;
   logic [DATA_W-1:0] src2;
   logic [63:0]       inst_to_the_next;
   logic [DATA_W-1:0] io_data_to_the_next;
   logic              memory1_stall;
   logic [ADDR_W-1:0] addrb;
   logic [DATA_W-1:0] dinb;
   logic [3:0]        web;
   logic              enb;
   logic              io_in_ready;
   logic              io_in_valid;
   logic [DATA_W-1:0] io_in_data;
   logic              io_out_valid;
   logic              io_out_ready;
   logic [DATA_W-1:0] io_out_data;
   logic [31:0]       stall_cycles;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   memory1 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clk                 (clk),
      .rstn                (rstn),
      .interlock           (interlock),
      .memory2_stall       (memory2_stall),
      .inst                (inst),
      .src1                (src1),
      .src2                (src2),
      .inst_to_the_next    (inst_to_the_next),
      .io_data_to_the_next (io_data_to_the_next),
      .memory1_stall       (memory1_stall),
      .addrb               (addrb),
      .dinb                (dinb),
      .web                 (web),
      .enb                 (enb),
      .io_in_ready         (io_in_ready),
      .io_in_valid         (io_in_valid),
      .io_in_data          (io_in_data),
      .io_out_valid        (io_out_valid),
      .io_out_ready        (io_out_ready),
      .io_out_data         (io_out_data),
      .stall_cycles        (stall_cycles)
   );

   function automatic logic [63:0] mk(input logic [7:0] op, input logic [15:0] im);
      return {op, 40'h0, im};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int vcnt;
      int xcnt;
      rstn = 1'b0; interlock = 1'b0; memory2_stall = 1'b0;
      inst = NOP_INST; src1 = '0; src2 = '0;
      io_in_valid = 1'b0; io_in_data = '0; io_out_ready = 1'b0;
      tick(); tick();

      // Reset state
      check("rst_inst",   inst_to_the_next, 64'h0);
      check("rst_iodata", io_data_to_the_next, 0);
      check("rst_inrdy",  io_in_ready, 0);
      check("rst_outvld", io_out_valid, 0);
      check("rst_outdat", io_out_data, 0);
      check("rst_stcnt",  stall_cycles, 0);
      check("rst_stall",  memory1_stall, 0);
      check("rst_enb",    enb, 0);
      check("rst_web",    web, 0);
      rstn = 1'b1;
      tick();

      // STORE: 0x100 + (-4) = 0xFC
      inst = mk(OP_STORE, 16'hFFFC); src1 = 32'h100; src2 = 32'hDEADBEEF;
      #1;
      check("st_enb",   enb, 1);
      check("st_web",   web, 4'hF);
      check("st_addrb", addrb, 17'h000FC);
      check("st_dinb",  dinb, 32'hDEADBEEF);
      tick();
      check("st_fwd", inst_to_the_next, mk(OP_STORE, 16'hFFFC));

      // LOAD held by downstream stall for 3 cycles
      inst = mk(OP_LOAD, 16'h0000); src1 = 32'h10; memory2_stall = 1'b1; interlock = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("ld_hold_enb", enb, 0);
         tick();
         check("ld_hold_inst", inst_to_the_next, mk(OP_STORE, 16'hFFFC));
      end
      memory2_stall = 1'b0; interlock = 1'b0;
      #1;
      check("ld_rel_enb",   enb, 1);
      check("ld_rel_web",   web, 0);
      check("ld_rel_addrb", addrb, 17'h00010);
      tick();
      check("ld_fwd", inst_to_the_next, mk(OP_LOAD, 16'h0000));

      // Address wrap: 0xFFFFFFF0 + 0x20 = 0x10
      inst = mk(OP_LOAD, 16'h0020); src1 = 32'hFFFF_FFF0;
      #1;
      check("wrap_addrb", addrb, 17'h00010);
      check("wrap_enb",   enb, 1);
      tick();

      // IN: five stalled cycles, data 0x41 on the last
      inst = mk(OP_IN, 16'h0000); io_in_data = 32'h41;
      #1;
      check("in_idle_stall", memory1_stall, 1);
      check("in_idle_enb",   enb, 0);
      tick();
      check("in_rdy",    io_in_ready, 1);
      check("in_bubble", inst_to_the_next, 64'h0);
      check("in_cnt1",   stall_cycles, 1);
      tick(); tick(); tick();
      check("in_wait_stall", memory1_stall, 1);
      io_in_valid = 1'b1;
      tick();
      io_in_valid = 1'b0;
      check("in_data",      io_data_to_the_next, 32'h41);
      check("in_rdy_drop",  io_in_ready, 0);
      check("in_done_stall", memory1_stall, 0);
      check("in_done_bubble", inst_to_the_next, 64'h0);
      tick();
      check("in_fwd", inst_to_the_next, mk(OP_IN, 16'h0000));
      check("in_cnt", stall_cycles, 5);
      inst = NOP_INST;
      #1;
      check("in_idle_after", memory1_stall, 0);
      tick();

      // OUT: ready low for 2 cycles of valid, then one transfer
      inst = mk(OP_OUT, 16'h0000); src2 = 32'h7A; io_out_ready = 1'b0;
      #1;
      check("out_idle_stall", memory1_stall, 1);
      tick();
      check("out_vld",  io_out_valid, 1);
      check("out_data", io_out_data, 32'h7A);
      vcnt = 0; xcnt = 0;
      for (int c = 0; c < 4; c++) begin
         io_out_ready = (c >= 2);
         #1;
         if (io_out_valid) vcnt++;
         if (io_out_valid && io_out_ready) xcnt++;
         tick();
      end
      inst = NOP_INST; io_out_ready = 1'b0;
      check("out_vld_cycles", vcnt, 3);
      check("out_xfers",      xcnt, 1);
      check("out_fwd",        inst_to_the_next, mk(OP_OUT, 16'h0000));
      check("out_vld_off",    io_out_valid, 0);
      check("out_cnt",        stall_cycles, 9);
      tick();
      check("out_idle_stall_off", memory1_stall, 0);

      // Asynchronous reset in the middle of IN_WAIT
      inst = mk(OP_IN, 16'h0000); io_in_data = 32'h99;
      tick();
      check("rin_rdy", io_in_ready, 1);
      #2;
      rstn = 1'b0; inst = NOP_INST;
      #1;
      check("rin_rdy0",   io_in_ready, 0);
      check("rin_iodata", io_data_to_the_next, 0);
      check("rin_inst",   inst_to_the_next, 64'h0);
      check("rin_cnt",    stall_cycles, 0);
      check("rin_stall",  memory1_stall, 0);
      check("rin_enb",    enb, 0);
      check("rin_web",    web, 0);
      tick();
      rstn = 1'b1;
      tick();
      check("rin_idle_rdy", io_in_ready, 0);
      check("rin_idle_cnt", stall_cycles, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/memory1.md
Name: memory1

Overview:
- First memory stage of the 2nd-core pipeline, directly upstream of memory2.
- Computes the effective address for LOAD/STORE and issues the BRAM port-B access, so read data appears on doutb while the instruction sits in memory2.
- Runs the blocking IN/OUT handshakes to the I/O unit with a small FSM and stalls the pipeline while they are outstanding.
- Forwards the instruction word (and IN data) to memory2.

Parameters:
ADDR_W, 17, BRAM word-address width
DATA_W, 32, data width of operands, BRAM and I/O

Ports:
clk  in  1  clock, all state updates on posedge
rstn  in  1  asynchronous active-low reset
interlock  in  1  pipeline interlock from hazard unit
memory2_stall  in  1  memory2 cannot accept a new instruction
inst  in  64  instruction word from execute
src1  in  DATA_W  base register value
src2  in  DATA_W  store / OUT data value
inst_to_the_next  out  64  instruction word to memory2
io_data_to_the_next  out  DATA_W  IN result travelling with the instruction
memory1_stall  out  1  memory1 holding its instruction (to upstream and hazard unit)
addrb  out  ADDR_W  BRAM port-B word address
dinb  out  DATA_W  BRAM port-B write data
web  out  4  BRAM port-B byte write enables
enb  out  1  BRAM port-B enable
io_in_ready  out  1  memory1 accepts a byte/word from the I/O unit
io_in_valid  in  1  I/O unit offers data
io_in_data  in  DATA_W  input data
io_out_valid  out  1  memory1 offers output data
io_out_ready  in  1  I/O unit accepts output data
io_out_data  out  DATA_W  output data
stall_cycles  out  32  count of cycles with memory1_stall high

Behaviour:
- Opcode field is inst[63:56]. Codes are LOAD, STORE, IN and OUT; anything else passes through. 64'h0 is NOP/bubble.
- Immediate is inst[15:0], sign-extended.
- ea = src1 + sext(imm), mod 2^32. addrb = ea[ADDR_W-1:0], with upper bits ignored. This is combinational from inst/src1, registered only inside the BRAM.
- advance = ~memory1_stall & (~memory2_stall | ~interlock).
- On advance, inst_to_the_next <= inst. On no advance, it holds.
- enb = advance & (LOAD|STORE). web = 4'hF iff advance & STORE, else 4'h0. dinb = src2.
- With enb low, the BRAM output register holds, so doutb stays stable under downstream stall.
- FSM states:
  - IDLE: IN or OUT with advance clear → hold. IN with (~memory2_stall|~interlock) → IN_WAIT. OUT → OUT_WAIT. In both cases inst is not yet forwarded.
  - IN_WAIT: memory1_stall=1, io_in_ready=1. On io_in_valid: capture io_in_data into io_data_to_the_next, go to DONE.
  - OUT_WAIT: memory1_stall=1, io_out_valid=1, io_out_data=src2 (registered at entry). On io_out_ready: go to DONE.
  - DONE: memory1_stall=0. The instruction advances under the normal rule, then the FSM returns to IDLE. If downstream is stalled, DONE is held.
- A transfer completes in the same cycle its valid&ready are both high; the handshake is not re-asserted in DONE.
- While in IN_WAIT or OUT_WAIT, inst_to_the_next is driven to 64'h0 (bubble) on each cycle memory2 is not stalled.
- inst and src1/src2 are held stable by upstream while memory1_stall=1.
- Reset, asynchronous on rstn low, at any point including mid-handshake:
  - State = IDLE.
  - inst_to_the_next = 0, io_data_to_the_next = 0.
  - io_in_ready = 0, io_out_valid = 0, io_out_data = 0.
  - stall_cycles = 0.
  - An I/O transfer in flight is abandoned.
  - addrb/dinb/web/enb are combinational; after reset, web=0 and enb=0 because memory1_stall=0 and inst is NOP until upstream supplies a non-NOP word.
- stall_cycles increments each cycle memory1_stall=1 and saturates at 32'hFFFF_FFFF.

Decomposition:
- Package mem_pkg holds:
  - opcode localparams: OP_LOAD, OP_STORE, OP_IN, OP_OUT, NOP_INST = 64'h0
  - field position constants for opcode and imm
  - the FSM state enum (IDLE, IN_WAIT, OUT_WAIT, DONE)
- One sub-module, memory1_io_fsm, is natural: it owns the state register, the handshakes, the data capture and the stall output. Address generation and the pipeline register stay in the top module.

Test Plan:
- STORE, src1=0x100, imm=0xFFFC, src2=0xDEADBEEF, no stalls → same cycle enb=1, web=4'hF, addrb=0x0FC, dinb=0xDEADBEEF. Next cycle inst_to_the_next=STORE word.
- LOAD at addr 0x10 with memory2_stall=1 and interlock=1 for 3 cycles → enb=0 and inst_to_the_next held for 3 cycles. enb=1 on the release cycle.
- IN with io_in_valid arriving 5 cycles later carrying 0x41 → memory1_stall high for 5 cycles, with bubbles forwarded. Then io_data_to_the_next=0x41, IN word forwarded. stall_cycles=5.
- OUT with src2=0x7A, io_out_ready low for 2 cycles → io_out_valid high for 3 cycles, io_out_data=0x7A, a single transfer, then IDLE.
- rstn pulsed low mid-IN_WAIT → all registered outputs 0 asynchronously, state IDLE, io_in_ready=0 before the next clock edge.
- src1=0xFFFF_FFF0, imm=0x0020 → ea wraps to 0x10, addrb=0x00010.
